// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer: one request -> one or two word beats
// Handles misaligned accesses that cross a word boundary and extends load data.
module mem_access_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t state, state_nx;

   logic              we_q, uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q, buf_lo, rsp_q;

   logic [1:0]        off;
   logic [2:0]        nb;
   logic [7:0]        mask8;
   logic [63:0]       wd64;
   logic              span;
   logic [ADDR_W-1:0] word_addr;
   logic [63:0]       data64;
   logic [31:0]       shifted;
   logic [31:0]       load_ext;
   logic              load_rsp;

   assign off       = addr_q[1:0];
   assign wd64      = {32'b0, wdata_q} << {off, 3'b000};
   assign span      = ({1'b0, off} + nb) > 3'd4;
   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

   always_comb begin
      nb    = 3'd4;
      mask8 = 8'h0F;
      case (size_q)
         2'b00: begin nb = 3'd1; mask8 = 8'h01; end
         2'b01: begin nb = 3'd2; mask8 = 8'h03; end
         default: begin nb = 3'd4; mask8 = 8'h0F; end
      endcase
      mask8 = mask8 << off;
   end

   // Non-spanning accesses see an all-zero upper word, so buf_hi never needs storing.
   assign data64  = (state == ACC1) ? {mem_rdata, buf_lo} : {32'b0, mem_rdata};
   assign shifted = 32'(data64 >> {off, 3'b000});

   always_comb begin
      load_ext = shifted;
      case (size_q)
         2'b00: load_ext = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         2'b01: load_ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   always_comb begin
      state_nx  = state;
      load_rsp  = 1'b0;
      req_ready = 1'b0;
      mem_valid = 1'b0;
      rsp_valid = 1'b0;
      mem_addr  = word_addr;
      mem_be    = mask8[3:0];
      mem_wdata = wd64[31:0];
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = ACC0;
         end
         ACC0: begin
            mem_valid = 1'b1;
            if (mem_ready) begin
               state_nx = span ? ACC1 : RESP;
               load_rsp = !span;
            end
         end
         ACC1: begin
            mem_valid = 1'b1;
            mem_addr  = word_addr + ADDR_W'(4);
            mem_be    = mask8[7:4];
            mem_wdata = wd64[63:32];
            if (mem_ready) begin
               state_nx = RESP;
               load_rsp = 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign mem_we    = we_q;
   assign rsp_rdata = rsp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         buf_lo  <= '0;
         rsp_q   <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         if (state == ACC0 && mem_ready) buf_lo <= mem_rdata;
         if (load_rsp) rsp_q <= we_q ? '0 : load_ext;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit
// Vector table for single requests plus hand sequences for stall and reset.
module tb_mem_access_unit;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        mem_valid, mem_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   int total = 0;
   int bad   = 0;

   mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr, wdata, rd0, rd1;
      int          beats;
      logic [31:0] a0;
      logic [3:0]  be0;
      logic [31:0] wd0;
      logic [31:0] a1;
      logic [3:0]  be1;
      logic [31:0] wd1;
      logic [31:0] rsp;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] rd0, logic [31:0] rd1, int beats,
                               logic [31:0] a0, logic [3:0] be0, logic [31:0] wd0,
                               logic [31:0] a1, logic [3:0] be1, logic [31:0] wd1,
                               logic [31:0] rsp);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.rd0 = rd0; v.rd1 = rd1; v.beats = beats;
      v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
      v.rsp = rsp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int  b;
      bit  done;
      b    = 0;
      done = 0;
      @(negedge clk);
      chk($sformatf("v%0d req_ready_idle", idx), 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
      req_addr = v.addr; req_wdata = v.wdata; mem_ready = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 8 && !done; n++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (mem_valid) begin
            chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.we));
            if (b == 0) begin
               chk($sformatf("v%0d addr0", idx), mem_addr, v.a0);
               chk($sformatf("v%0d be0", idx), 32'(mem_be), 32'(v.be0));
               if (v.we) chk($sformatf("v%0d wd0", idx), mem_wdata, v.wd0);
               mem_rdata = v.rd0;
            end else if (b == 1) begin
               chk($sformatf("v%0d addr1", idx), mem_addr, v.a1);
               chk($sformatf("v%0d be1", idx), 32'(mem_be), 32'(v.be1));
               if (v.we) chk($sformatf("v%0d wd1", idx), mem_wdata, v.wd1);
               mem_rdata = v.rd1;
            end
            b++;
         end
         if (rsp_valid) begin
            chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.beats + 1));
            chk($sformatf("v%0d beats", idx), 32'(b), 32'(v.beats));
            chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.rsp);
            done = 1;
         end
      end
      if (!done) chk($sformatf("v%0d rsp_timeout", idx), 32'd0, 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d rsp_pulse", idx), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d rsp_held", idx), rsp_rdata, v.rsp);
   endtask

   initial begin
      //             we    sz     u     addr          wdata         rd0           rd1          bt  a0            be0      wd0           a1            be1      wd1           rsp
      vecs[0]  = mk(1'b0, 2'b10, 1'b0, 32'h00000008, 32'h0,        32'h0B0A0908, 32'h0,       1, 32'h00000008, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0B0A0908);
      vecs[1]  = mk(1'b0, 2'b00, 1'b0, 32'h0000000D, 32'h0,        32'h0F0E800C, 32'h0,       1, 32'h0000000C, 4'b0010, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFFFF80);
      vecs[2]  = mk(1'b0, 2'b00, 1'b1, 32'h0000000D, 32'h0,        32'h0F0E800C, 32'h0,       1, 32'h0000000C, 4'b0010, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h00000080);
      vecs[3]  = mk(1'b1, 2'b01, 1'b0, 32'h00000006, 32'h1234ABCD, 32'h0,        32'h0,       1, 32'h00000004, 4'b1100, 32'hABCD0000, 32'h0,        4'b0000, 32'h0,        32'h0);
      vecs[4]  = mk(1'b1, 2'b10, 1'b0, 32'h0000000A, 32'hDDCCBBAA, 32'h0,        32'h0,       2, 32'h00000008, 4'b1100, 32'hBBAA0000, 32'h0000000C, 4'b0011, 32'h0000DDCC, 32'h0);
      vecs[5]  = mk(1'b0, 2'b10, 1'b0, 32'h00000003, 32'h0,        32'h03020100, 32'h07060504, 2, 32'h00000000, 4'b1000, 32'h0,       32'h00000004, 4'b0111, 32'h0,        32'h06050403);
      vecs[6]  = mk(1'b0, 2'b01, 1'b0, 32'h00000002, 32'h0,        32'h80017777, 32'h0,       1, 32'h00000000, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF8001);
      vecs[7]  = mk(1'b0, 2'b01, 1'b1, 32'h00000003, 32'h0,        32'h9A112233, 32'h445566F7, 2, 32'h00000000, 4'b1000, 32'h0,       32'h00000004, 4'b0001, 32'h0,        32'h0000F79A);
      vecs[8]  = mk(1'b0, 2'b01, 1'b0, 32'h00000003, 32'h0,        32'h9A112233, 32'h445566F7, 2, 32'h00000000, 4'b1000, 32'h0,       32'h00000004, 4'b0001, 32'h0,        32'hFFFFF79A);
      vecs[9]  = mk(1'b1, 2'b00, 1'b0, 32'h00000003, 32'h123456EF, 32'h0,        32'h0,       1, 32'h00000000, 4'b1000, 32'hEF000000, 32'h0,        4'b0000, 32'h0,        32'h0);
      vecs[10] = mk(1'b0, 2'b10, 1'b1, 32'hFFFFFFFE, 32'h0,        32'hBEEF0000, 32'h0000CAFE, 2, 32'hFFFFFFFC, 4'b1100, 32'h0,       32'h00000000, 4'b0011, 32'h0,        32'hCAFEBEEF);
      vecs[11] = mk(1'b0, 2'b11, 1'b0, 32'h00000010, 32'h0,        32'h55AA55AA, 32'h0,       1, 32'h00000010, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h55AA55AA);
      vecs[12] = mk(1'b1, 2'b10, 1'b0, 32'hFFFFFFFD, 32'h11223344, 32'h0,        32'h0,       2, 32'hFFFFFFFC, 4'b1110, 32'h22334400, 32'h00000000, 4'b0001, 32'h00000011, 32'h0);

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; mem_ready = 1'b1; mem_rdata = '0;
      #2;
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset mem_valid", 32'(mem_valid), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

      // Memory stalls the first beat; outputs must hold until the ready beat.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h00000020; mem_ready = 1'b0; mem_rdata = 32'h13579BDF;
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         chk("stall mem_valid", 32'(mem_valid), 32'd1);
         chk("stall mem_addr", mem_addr, 32'h00000020);
         chk("stall mem_be", 32'(mem_be), 32'hF);
         chk("stall req_ready", 32'(req_ready), 32'd0);
         chk("stall rsp_valid", 32'(rsp_valid), 32'd0);
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("stall rsp_valid_end", 32'(rsp_valid), 32'd1);
      chk("stall rsp_rdata", rsp_rdata, 32'h13579BDF);
      @(negedge clk);
      chk("stall back_idle", 32'(req_ready), 32'd1);

      // Reset asserted while the second beat of a spanning store is pending.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0000000A;
      req_wdata = 32'hDDCCBBAA;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst acc0_be", 32'(mem_be), 32'hC);
      @(negedge clk);
      chk("rst acc1_valid", 32'(mem_valid), 32'd1);
      chk("rst acc1_addr", mem_addr, 32'h0000000C);
      rst_n = 1'b0;
      #1;
      chk("rst async mem_valid", 32'(mem_valid), 32'd0);
      chk("rst async req_ready", 32'(req_ready), 32'd1);
      chk("rst async rsp_rdata", rsp_rdata, 32'd0);
      @(negedge clk);
      chk("rst held rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst held mem_valid", 32'(mem_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst after rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst after req_ready", 32'(req_ready), 32'd1);
      run_vec(100, vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
